// File: rtl/afu_transpose_pkg.sv
// Shared constants and helpers for the ping-pong tile transpose block.
// No ports; imported by afu_transpose_pp and tile_bank.
package afu_transpose_pkg;

  localparam int unsigned LINE_WIDTH_DEFAULT = 512;
  localparam int unsigned DATA_WIDTH_DEFAULT = 16;

  localparam logic MODE_TRANSPOSE = 1'b0;
  localparam logic MODE_BYPASS    = 1'b1;

  // Number of elements per line, which is also the tile edge N.
  function automatic int unsigned elems_per_line(input int unsigned line_width,
                                                 input int unsigned data_width);
    return line_width / data_width;
  endfunction

  // Ceiling log2; never returns less than 1 so index vectors stay legal.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 1;
    for (int i = 1; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) r = 32'(i + 1);
    end
    return r;
  endfunction

endpackage

// File: rtl/tile_bank.sv
// One N x N tile of DATA_WIDTH elements.
// Ports: clk; we/wr_row/wr_data write one full row; rd_idx selects the
// row presented on row_c and the column presented on col_c (both combinational).
module tile_bank
  import afu_transpose_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEFAULT,
  parameter int unsigned N          = elems_per_line(LINE_WIDTH_DEFAULT, DATA_WIDTH_DEFAULT),
  parameter int unsigned ROW_W      = clog2(N)
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [ROW_W-1:0]        wr_row,
  input  logic [N*DATA_WIDTH-1:0] wr_data,
  input  logic [ROW_W-1:0]        rd_idx,
  output logic [N*DATA_WIDTH-1:0] row_c,
  output logic [N*DATA_WIDTH-1:0] col_c
);

  logic [N*DATA_WIDTH-1:0] mem [N];

  // Row storage; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) mem[wr_row] <= wr_data;
  end

  // Row select for bypass, column gather for transpose.
  always_comb begin
    row_c = mem[rd_idx];
    col_c = '0;
    for (int i = 0; i < N; i++) begin
      col_c[i*DATA_WIDTH +: DATA_WIDTH] = mem[i][rd_idx*DATA_WIDTH +: DATA_WIDTH];
    end
  end

endmodule

// File: rtl/afu_transpose_pp.sv
// Ping-pong N x N tile transposer between the AFU read path and write-back.
// Ports: clk, reset (sync, active-high); mode (0 transpose / 1 bypass, sampled
// on each tile's first row); input_fifo_din/we/full write side;
// output_fifo_dout/re/empty read side (dout registered, data the cycle after re);
// overflow/underflow sticky error flags.
module afu_transpose_pp
  import afu_transpose_pkg::*;
#(
  parameter int unsigned LINE_WIDTH = LINE_WIDTH_DEFAULT,
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mode,
  input  logic [LINE_WIDTH-1:0] input_fifo_din,
  input  logic                  input_fifo_we,
  output logic                  input_fifo_full,
  output logic [LINE_WIDTH-1:0] output_fifo_dout,
  input  logic                  output_fifo_re,
  output logic                  output_fifo_empty,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int unsigned N     = elems_per_line(LINE_WIDTH, DATA_WIDTH);
  localparam int unsigned ROW_W = clog2(N);
  localparam logic [ROW_W-1:0] LAST = ROW_W'(N - 1);

  logic             wr_bank;
  logic             rd_bank;
  logic [ROW_W-1:0] wr_row;
  logic [ROW_W-1:0] rd_col;
  logic [1:0]       bank_valid;
  logic [1:0]       bank_mode;

  logic                  wr_acc_c;
  logic                  rd_acc_c;
  logic [LINE_WIDTH-1:0] rd_line_c;
  logic [LINE_WIDTH-1:0] row_c [2];
  logic [LINE_WIDTH-1:0] col_c [2];

  // Writer is blocked only when its target bank still holds an unread tile.
  assign input_fifo_full   = bank_valid[wr_bank];
  assign output_fifo_empty = !bank_valid[rd_bank];
  assign wr_acc_c          = input_fifo_we && !input_fifo_full;
  assign rd_acc_c          = output_fifo_re && !output_fifo_empty;
  assign rd_line_c         = (bank_mode[rd_bank] == MODE_BYPASS) ? row_c[rd_bank]
                                                                 : col_c[rd_bank];

  for (genvar b = 0; b < 2; b++) begin : g_bank
    tile_bank #(
      .DATA_WIDTH(DATA_WIDTH),
      .N         (N),
      .ROW_W     (ROW_W)
    ) u_bank (
      .clk    (clk),
      .we     (wr_acc_c && (wr_bank == 1'(b))),
      .wr_row (wr_row),
      .wr_data(input_fifo_din),
      .rd_idx (rd_col),
      .row_c  (row_c[b]),
      .col_c  (col_c[b])
    );
  end

  // Pointers, valid/mode bits, output register and sticky flags.
  // Writer and reader never touch the same bank_valid bit in one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_bank          <= 1'b0;
      rd_bank          <= 1'b0;
      wr_row           <= '0;
      rd_col           <= '0;
      bank_valid       <= 2'b00;
      bank_mode        <= 2'b00;
      output_fifo_dout <= '0;
      overflow         <= 1'b0;
      underflow        <= 1'b0;
    end else begin
      if (wr_acc_c) begin
        if (wr_row == '0) bank_mode[wr_bank] <= mode;
        if (wr_row == LAST) begin
          bank_valid[wr_bank] <= 1'b1;
          wr_bank             <= !wr_bank;
        end
        wr_row <= wr_row + 1'b1;
      end
      if (input_fifo_we && input_fifo_full) overflow <= 1'b1;

      if (rd_acc_c) begin
        output_fifo_dout <= rd_line_c;
        if (rd_col == LAST) begin
          bank_valid[rd_bank] <= 1'b0;
          rd_bank             <= !rd_bank;
        end
        rd_col <= rd_col + 1'b1;
      end
      if (output_fifo_re && output_fifo_empty) underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_afu_transpose_pp.sv
// Bench for afu_transpose_pp at DATA_WIDTH 16, 32 and 8 (N = 32, 16, 64),
// checked against a line-queue reference model.
module tb_afu_transpose_pp;

  localparam int unsigned LW = 512;

  logic          clk = 1'b0;
  logic          reset;
  logic [LW-1:0] din;
  logic          we [3];
  logic          re [3];
  logic          md [3];
  logic [LW-1:0] dout [3];
  logic          full [3];
  logic          empty [3];
  logic          ov [3];
  logic          un [3];

  always #5 clk = ~clk;

  afu_transpose_pp #(.LINE_WIDTH(LW), .DATA_WIDTH(16)) u_dut16 (
    .clk(clk), .reset(reset), .mode(md[0]), .input_fifo_din(din),
    .input_fifo_we(we[0]), .input_fifo_full(full[0]), .output_fifo_dout(dout[0]),
    .output_fifo_re(re[0]), .output_fifo_empty(empty[0]), .overflow(ov[0]),
    .underflow(un[0]));

  afu_transpose_pp #(.LINE_WIDTH(LW), .DATA_WIDTH(32)) u_dut32 (
    .clk(clk), .reset(reset), .mode(md[1]), .input_fifo_din(din),
    .input_fifo_we(we[1]), .input_fifo_full(full[1]), .output_fifo_dout(dout[1]),
    .output_fifo_re(re[1]), .output_fifo_empty(empty[1]), .overflow(ov[1]),
    .underflow(un[1]));

  afu_transpose_pp #(.LINE_WIDTH(LW), .DATA_WIDTH(8)) u_dut8 (
    .clk(clk), .reset(reset), .mode(md[2]), .input_fifo_din(din),
    .input_fifo_we(we[2]), .input_fifo_full(full[2]), .output_fifo_dout(dout[2]),
    .output_fifo_re(re[2]), .output_fifo_empty(empty[2]), .overflow(ov[2]),
    .underflow(un[2]));

  int tests = 0;
  int fails = 0;

  // Reference model: accepted lines in arrival order, one mode per tile.
  int            s;
  int            dw;
  int            nn;
  int            rd_idx;
  logic [LW-1:0] mq [$];
  logic          mm [$];
  logic [LW-1:0] exp_dout;
  logic          exp_ov;
  logic          exp_un;

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] expv);
    tests++;
    assert (obs === expv)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sel(input int k);
    s  = k;
    dw = (k == 0) ? 16 : (k == 1) ? 32 : 8;
    nn = LW / dw;
  endtask

  task automatic do_reset();
    for (int k = 0; k < 3; k++) begin
      we[k] = 1'b0; re[k] = 1'b0; md[k] = 1'b0;
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    mq.delete();
    mm.delete();
    rd_idx = 0; exp_dout = '0; exp_ov = 1'b0; exp_un = 1'b0;
    chk("rst_full", full[s], 1'b0);
    chk("rst_empty", empty[s], 1'b1);
    chk("rst_dout", dout[s], '0);
    chk("rst_overflow", ov[s], 1'b0);
    chk("rst_underflow", un[s], 1'b0);
  endtask

  // Output line j of the head tile: transposed elements or the row itself.
  function automatic logic [LW-1:0] xform(input int j, input logic m);
    logic [LW-1:0] r, ln;
    if (m) return mq[j];
    r = '0;
    for (int i = 0; i < nn; i++) begin
      ln = mq[i];
      for (int b = 0; b < dw; b++) r[i*dw + b] = ln[j*dw + b];
    end
    return r;
  endfunction

  function automatic logic [LW-1:0] pat(input int r);
    logic [LW-1:0] l;
    int            v;
    l = '0;
    for (int c = 0; c < nn; c++) begin
      v = (r << (dw / 2)) | c;
      for (int b = 0; b < dw; b++) l[c*dw + b] = v[b];
    end
    return l;
  endfunction

  function automatic logic [LW-1:0] rnd();
    logic [LW-1:0] l;
    for (int k = 0; k < LW / 32; k++) l[k*32 +: 32] = $urandom;
    return l;
  endfunction

  task automatic do_write(input logic [LW-1:0] d, input logic m);
    din = d; md[s] = m; we[s] = 1'b1;
    if (mq.size() < 2 * nn) begin
      if (mq.size() % nn == 0) mm.push_back(m);
      mq.push_back(d);
    end else begin
      exp_ov = 1'b1;
    end
    tick();
    we[s] = 1'b0;
    md[s] = $urandom_range(0, 1);
    chk("wr_full", full[s], mq.size() == 2 * nn);
    chk("wr_empty", empty[s], mq.size() < nn);
    chk("wr_overflow", ov[s], exp_ov);
  endtask

  task automatic do_read(input string tag);
    re[s] = 1'b1;
    if (mq.size() >= nn) begin
      exp_dout = xform(rd_idx, mm[0]);
      rd_idx++;
      if (rd_idx == nn) begin
        repeat (nn) void'(mq.pop_front());
        void'(mm.pop_front());
        rd_idx = 0;
      end
    end else begin
      exp_un = 1'b1;
    end
    tick();
    re[s] = 1'b0;
    chk(tag, dout[s], exp_dout);
    chk("rd_empty", empty[s], mq.size() < nn);
    chk("rd_full", full[s], mq.size() == 2 * nn);
    chk("rd_underflow", un[s], exp_un);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    din = '0;
    sel(0);
    do_reset();

    // Reads while empty: dout holds at 0, underflow sticks, pointers stay put.
    repeat (3) do_read("empty_read_dout");

    // Transpose of the {row,col} pattern at N=32.
    for (int r = 0; r < nn; r++) do_write(pat(r), 1'b0);
    for (int j = 0; j < nn; j++) begin
      do_read("tr_pattern_line");
      if (j == 0)  chk("tr_line0_elem5", dout[0][5*16 +: 16], 16'h0500);
      if (j == 31) chk("tr_line31_elem0", dout[0][0 +: 16], 16'h001F);
    end

    // Bypass of random lines.
    for (int r = 0; r < nn; r++) do_write(rnd(), 1'b1);
    for (int j = 0; j < nn; j++) do_read("bypass_line");
    chk("bypass_empty_after", empty[0], 1'b1);

    // Ping-pong: fill both banks, drop one write, drain, refill.
    do_reset();
    for (int r = 0; r < 2 * nn; r++)
      do_write(rnd(), (r % nn == 0) ? ((r < nn) ? 1'b0 : 1'b1) : 1'($urandom_range(0, 1)));
    do_write(rnd(), 1'b0);
    for (int j = 0; j < nn; j++) do_read("pp_tileA_line");
    for (int r = 0; r < nn; r++) do_write(rnd(), (r == 0) ? 1'b0 : 1'($urandom_range(0, 1)));
    for (int j = 0; j < 2 * nn; j++) do_read("pp_tileBC_line");
    do_read("pp_underflow_hold");

    // Reset mid-tile discards the partial tile.
    do_reset();
    for (int r = 0; r < 10; r++) do_write(rnd(), 1'b1);
    do_reset();
    for (int r = 0; r < nn; r++) do_write(pat(r + 100), 1'b0);
    for (int j = 0; j < nn; j++) do_read("midrst_line");
    do_read("midrst_extra_read");

    // N=16: pattern transpose then random bypass.
    sel(1);
    do_reset();
    for (int r = 0; r < nn; r++) do_write(pat(r), 1'b0);
    for (int j = 0; j < nn; j++) do_read("n16_tr_line");
    for (int r = 0; r < nn; r++) do_write(rnd(), 1'b1);
    for (int j = 0; j < nn; j++) do_read("n16_bp_line");

    // N=64: random transpose, both banks in flight.
    sel(2);
    do_reset();
    for (int r = 0; r < 2 * nn; r++) do_write(rnd(), (r < nn) ? 1'b0 : 1'b1);
    do_write(rnd(), 1'b1);
    for (int j = 0; j < 2 * nn; j++) do_read("n64_line");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
